// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port DataMemory arbiter.
// Pure declarations: no logic, no latency, no flow control.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    // Word accesses only: the two byte-offset bits must be clear.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time wins.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant_id
);

    logic w_both;

    assign w_both        = i_req0 & i_req1;
    assign o_grant_valid = i_req0 | i_req1;
    assign o_grant_id    = w_both ? ~i_last_grant : (i_req1 ? REQ_M1 : REQ_M0);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin req/ack arbiter sharing one DataMemory between M0 and M1; one access in flight, ack 2 cycles after the request is seen.
// Requesters stall by holding req until ack. DMEM_ARB_ALIGN_CHECK_EN adds m0_err/m1_err for misaligned addresses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    ,
    output logic              m0_err,
    output logic              m1_err
`endif
);

    state_t            r_state;
    logic              r_last_grant;
    logic              r_gnt_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_m0_ack;
    logic              r_m1_ack;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    logic              w_gnt_vld;
    logic              w_gnt_id;
    logic              w_in_access;
    logic              w_aligned;

    rr_arbiter2 u_rr (
        .i_req0        (m0_req),
        .i_req1        (m1_req),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_gnt_vld),
        .o_grant_id    (w_gnt_id)
    );

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic r_m0_err;
    logic r_m1_err;

    assign w_aligned = is_word_aligned(r_addr[1:0]);
    assign m0_err    = r_m0_err;
    assign m1_err    = r_m1_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m0_err <= 1'b0;
            r_m1_err <= 1'b0;
        end else if (r_state == ACCESS) begin
            r_m0_err <= !w_aligned && (r_gnt_id == REQ_M0);
            r_m1_err <= !w_aligned && (r_gnt_id == REQ_M1);
        end else begin
            r_m0_err <= 1'b0;
            r_m1_err <= 1'b0;
        end
    end
`else
    // Misaligned addresses simply reach the containing word.
    assign w_aligned = 1'b1;
`endif

    // Memory strobes follow state directly, so a write in ACCESS commits even if reset hits that edge.
    assign w_in_access    = (r_state == ACCESS);
    assign mem_write      = w_in_access && w_aligned && r_we;
    assign mem_read       = w_in_access && w_aligned && !r_we;
    assign mem_address    = w_in_access ? r_addr  : '0;
    assign mem_write_data = w_in_access ? r_wdata : '0;

    assign m0_ack   = r_m0_ack;
    assign m1_ack   = r_m1_ack;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_M1;
            r_gnt_id     <= REQ_M0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    if (w_gnt_vld) begin
                        r_gnt_id     <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_we         <= (w_gnt_id == REQ_M1) ? m1_we    : m0_we;
                        r_addr       <= (w_gnt_id == REQ_M1) ? m1_addr  : m0_addr;
                        r_wdata      <= (w_gnt_id == REQ_M1) ? m1_wdata : m0_wdata;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_we && w_aligned) begin
                        if (r_gnt_id == REQ_M1) r_m1_rdata <= mem_read_data;
                        else                    r_m0_rdata <= mem_read_data;
                    end
                    r_m0_ack <= (r_gnt_id == REQ_M0);
                    r_m1_ack <= (r_gnt_id == REQ_M1);
                    r_state  <= ACK;
                end
                ACK: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word-addressed DataMemory (combinational read, write on clock edge).
// Define DMEM_ARB_ALIGN_CHECK_EN to also exercise the misaligned-access error path.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic          mem_write, mem_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic          m0_err, m1_err;
`endif

    logic [DW-1:0] mem [0:63];
    logic          pl_en = 1'b0;
    logic [5:0]    pl_idx = '0;
    logic [DW-1:0] pl_dat = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write)   mem[mem_address[7:2]] <= mem_write_data;
        else if (pl_en)  mem[pl_idx] <= pl_dat;
    end
    assign mem_read_data = mem[mem_address[7:2]];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_ack         (m0_ack),
        .m0_rdata       (m0_rdata),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_ack         (m1_ack),
        .m1_rdata       (m1_rdata),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        ,
        .m0_err         (m0_err),
        .m1_err         (m1_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [DW-1:0] dat);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_dat = dat;
        tick();
        pl_en  = 1'b0;
    endtask

    initial begin
        int n_gnt;
        logic gid [0:5];

        // Reset state
        repeat (2) tick();
        check("rst_state",  64'(dut.r_state), 64'(IDLE));
        check("rst_m0_ack", 64'(m0_ack), 64'd0);
        check("rst_m1_ack", 64'(m1_ack), 64'd0);
        check("rst_m0_rd",  64'(m0_rdata), 64'd0);
        check("rst_m1_rd",  64'(m1_rdata), 64'd0);
        check("rst_mem_we", 64'(mem_write), 64'd0);
        rst = 1'b0;
        tick();

        // M0 write 0xDEADBEEF to 0x10
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        tick();
        check("w_c1_we",   64'(mem_write), 64'd1);
        check("w_c1_rd",   64'(mem_read), 64'd0);
        check("w_c1_addr", 64'(mem_address), 64'h10);
        check("w_c1_wd",   64'(mem_write_data), 64'hDEADBEEF);
        check("w_c1_ack",  64'(m0_ack), 64'd0);
        tick();
        check("w_c2_ack",  64'(m0_ack), 64'd1);
        check("w_c2_we",   64'(mem_write), 64'd0);
        check("w_c2_m1",   64'(m1_ack), 64'd0);
        m0_req = 1'b0;
        tick();
        check("w_c3_ack",  64'(m0_ack), 64'd0);
        check("w_mem4",    64'(mem[4]), 64'hDEADBEEF);

        // M0 read 0x10
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        tick();
        check("r_c1_rd",   64'(mem_read), 64'd1);
        check("r_c1_we",   64'(mem_write), 64'd0);
        tick();
        check("r_c2_ack",  64'(m0_ack), 64'd1);
        check("r_c2_data", 64'(m0_rdata), 64'hDEADBEEF);
        check("r_c2_m1",   64'(m1_ack), 64'd0);
        m0_req = 1'b0;
        tick();

        // Simultaneous first requests after a fresh reset
        preload(6'd8, 32'h12345678);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h24; m1_wdata = 32'h55;
        tick();
        check("s_c1_addr", 64'(mem_address), 64'h20);
        check("s_c1_rd",   64'(mem_read), 64'd1);
        tick();
        check("s_c2_m0",   64'(m0_ack), 64'd1);
        check("s_c2_m1",   64'(m1_ack), 64'd0);
        check("s_c2_data", 64'(m0_rdata), 64'h12345678);
        m0_req = 1'b0;
        tick();
        check("s_c3_m0",   64'(m0_ack), 64'd0);
        tick();
        check("s_c4_we",   64'(mem_write), 64'd1);
        check("s_c4_addr", 64'(mem_address), 64'h24);
        tick();
        check("s_c5_m1",   64'(m1_ack), 64'd1);
        check("s_c5_m0",   64'(m0_ack), 64'd0);
        m1_req = 1'b0;
        tick();
        check("s_mem9",    64'(mem[9]), 64'h55);
        check("s_m1_rd",   64'(m1_rdata), 64'd0);

        // Continuous contention: both read, held through six grants
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h24;
        n_gnt = 0;
        for (int c = 0; c < 40 && n_gnt < 6; c++) begin
            tick();
            if (m0_ack && m1_ack) check("c_dual_ack", 64'd1, 64'd0);
            if (m0_ack || m1_ack) begin
                gid[n_gnt] = m1_ack;
                if (m1_ack) check("c_m1_data", 64'(m1_rdata), 64'h55);
                else        check("c_m0_data", 64'(m0_rdata), 64'h12345678);
                n_gnt++;
                if (n_gnt == 6) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end
        end
        check("c_count", 64'(n_gnt), 64'd6);
        for (int i = 0; i < n_gnt; i++)
            check($sformatf("c_gnt%0d", i), 64'(gid[i]), 64'(i % 2));
        tick();

        // Reset during ACCESS of an M1 write
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h30; m1_wdata = 32'hA5A5A5A5;
        tick();
        check("x_c1_we",   64'(mem_write), 64'd1);
        rst = 1'b1;
        tick();
        check("x_state",   64'(dut.r_state), 64'(IDLE));
        check("x_m1_ack",  64'(m1_ack), 64'd0);
        check("x_m0_ack",  64'(m0_ack), 64'd0);
        rst = 1'b0;
        m1_req = 1'b0;
        tick();
        check("x_m1_ack2", 64'(m1_ack), 64'd0);
        check("x_mem12",   64'(mem[12]), 64'hA5A5A5A5);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30;
        tick();
        tick();
        check("x_rd_ack",  64'(m0_ack), 64'd1);
        check("x_rd_data", 64'(m0_rdata), 64'hA5A5A5A5);
        m0_req = 1'b0;
        tick();

        // Requester changes address after latching
        preload(6'd16, 32'h40404040);
        preload(6'd17, 32'h44444444);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        tick();
        m0_addr = 32'h44;
        #1;
        check("i_addr",    64'(mem_address), 64'h40);
        tick();
        check("i_ack",     64'(m0_ack), 64'd1);
        check("i_data",    64'(m0_rdata), 64'h40404040);
        m0_req = 1'b0;
        tick();

`ifdef DMEM_ARB_ALIGN_CHECK_EN
        // Misaligned M1 write is refused with an error
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h13; m1_wdata = 32'h0BAD0BAD;
        tick();
        check("a_c1_we",   64'(mem_write), 64'd0);
        check("a_c1_rd",   64'(mem_read), 64'd0);
        tick();
        check("a_c2_ack",  64'(m1_ack), 64'd1);
        check("a_c2_err",  64'(m1_err), 64'd1);
        check("a_c2_m0e",  64'(m0_err), 64'd0);
        m1_req = 1'b0;
        tick();
        check("a_c3_err",  64'(m1_err), 64'd0);
        check("a_mem4",    64'(mem[4]), 64'hDEADBEEF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
